// File: rtl/uart_rx_multi.sv
// Oversampling UART receiver with majority-vote bit decisions.
// Received words land in a first-word-fall-through FIFO with error flags.
module uart_rx_multi #(
    parameter int OVERSAMPLE = 8,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          uart_rx_bclk,
    input  logic                          uart_rx_rst_n,
    input  logic                          uart_rx_pin_raw,
    output logic [DATA_BITS-1:0]          uart_rx_data,
    output logic                          uart_rx_perr,
    output logic                          uart_rx_ferr,
    output logic                          uart_rx_rdy,
    input  logic                          uart_rx_rd,
    output logic                          uart_rx_ovr,
    input  logic                          uart_rx_ovr_clr,
    output logic [$clog2(FIFO_DEPTH):0]   uart_rx_level,
    output logic                          uart_rx_busy
);

    localparam int HALF = OVERSAMPLE / 2;
    localparam int CW   = $clog2(OVERSAMPLE);
    localparam int ZW   = CW + 1;
    localparam int BIW  = 4;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;
    localparam int WW   = DATA_BITS + 2;
    localparam logic [ZW:0] FULL_TH = (ZW+1)'(OVERSAMPLE - 2);
    localparam logic [ZW:0] HALF_TH = (ZW+1)'(HALF);

    typedef enum logic [2:0] {
        IDLE,
        START_REST,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t state, state_nxt;

    logic [1:0]           sync;
    logic [1:0]           vld;
    logic                 pin;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        low_cnt;
    logic [ZW-1:0]        zeros;
    logic [ZW-1:0]        zeros_now;
    logic [BIW-1:0]       bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 armed;
    logic                 samp_zero;
    logic                 win_end;
    logic                 half_end;
    logic                 last_stop;
    logic                 full_bit;
    logic                 half_bit;
    logic                 final_dec;
    logic [WW-1:0]        word;

    // vld tracks when the synchroniser holds real line samples
    always_ff @(posedge uart_rx_bclk or negedge uart_rx_rst_n) begin
        if (!uart_rx_rst_n) begin
            sync <= 2'b11;
            vld  <= 2'b00;
        end else begin
            sync <= {sync[0], uart_rx_pin_raw};
            vld  <= {vld[0], 1'b1};
        end
    end

    assign pin       = sync[1];
    assign win_end   = (cnt == CW'(OVERSAMPLE - 1));
    assign half_end  = (cnt == CW'(HALF));
    assign last_stop = (stop_idx == 1'(STOP_BITS - 1));
    assign samp_zero = (cnt != '0) && !win_end && !pin;
    assign zeros_now = zeros + ZW'(samp_zero);
    assign full_bit  = !({zeros_now, 1'b0} > FULL_TH);
    assign half_bit  = !({zeros_now, 1'b0} > HALF_TH);
    assign final_dec = (state == STOP) && last_stop && half_end;
    assign word      = {ferr_q | ~half_bit, perr_q, shreg};

    always_ff @(posedge uart_rx_bclk or negedge uart_rx_rst_n) begin
        if (!uart_rx_rst_n) state <= IDLE;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:
                if (!pin && armed && low_cnt == CW'(HALF - 1))
                    state_nxt = START_REST;
            START_REST:
                if (cnt == CW'(HALF - 1)) state_nxt = DATA;
            DATA:
                if (win_end && bit_idx == BIW'(DATA_BITS - 1))
                    state_nxt = (PARITY != 0) ? PAR : STOP;
            PAR:
                if (win_end) state_nxt = STOP;
            STOP:
                if (final_dec) state_nxt = IDLE;
            default:
                state_nxt = IDLE;
        endcase
    end

    // A low final stop bit disarms start detection until the line goes high
    always_ff @(posedge uart_rx_bclk or negedge uart_rx_rst_n) begin
        if (!uart_rx_rst_n) begin
            cnt      <= '0;
            low_cnt  <= '0;
            zeros    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            armed    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt      <= '0;
                    zeros    <= '0;
                    bit_idx  <= '0;
                    stop_idx <= 1'b0;
                    perr_q   <= 1'b0;
                    ferr_q   <= 1'b0;
                    if (pin) begin
                        low_cnt <= '0;
                        armed   <= armed | vld[1];
                    end else if (low_cnt != CW'(HALF)) begin
                        low_cnt <= low_cnt + 1'b1;
                    end
                end
                START_REST: begin
                    cnt <= (cnt == CW'(HALF - 1)) ? '0 : cnt + 1'b1;
                end
                default: begin
                    cnt   <= win_end ? '0 : cnt + 1'b1;
                    zeros <= win_end ? '0 : zeros_now;
                    if (state == DATA && win_end) begin
                        shreg   <= {full_bit, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                    end
                    if (state == PAR && win_end)
                        perr_q <= (^shreg) ^ full_bit ^ 1'(PARITY == 2);
                    if (state == STOP && !last_stop && win_end) begin
                        ferr_q   <= ferr_q | ~full_bit;
                        stop_idx <= 1'b1;
                    end
                    if (final_dec) begin
                        low_cnt <= '0;
                        armed   <= half_bit;
                    end
                end
            endcase
        end
    end

    logic [WW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] rptr, wptr;
    logic [LW-1:0] level;
    logic          full, rdy, pop, wr, ovf;
    logic [WW-1:0] head;

    assign full = (level == LW'(FIFO_DEPTH));
    assign rdy  = (level != '0);
    assign pop  = uart_rx_rd && rdy;
    assign wr   = final_dec && (!full || pop);
    assign ovf  = final_dec && full && !pop;
    assign head = mem[rptr];

    always_ff @(posedge uart_rx_bclk) begin
        if (wr) mem[wptr] <= word;
    end

    always_ff @(posedge uart_rx_bclk or negedge uart_rx_rst_n) begin
        if (!uart_rx_rst_n) begin
            rptr        <= '0;
            wptr        <= '0;
            level       <= '0;
            uart_rx_ovr <= 1'b0;
        end else begin
            if (wr)  wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            if (wr && !pop)      level <= level + 1'b1;
            else if (pop && !wr) level <= level - 1'b1;
            if (ovf)                  uart_rx_ovr <= 1'b1;
            else if (uart_rx_ovr_clr) uart_rx_ovr <= 1'b0;
        end
    end

    // Head outputs read as zero while the FIFO is empty
    assign uart_rx_data  = rdy ? head[DATA_BITS-1:0] : '0;
    assign uart_rx_perr  = rdy ? head[DATA_BITS]     : 1'b0;
    assign uart_rx_ferr  = rdy ? head[DATA_BITS+1]   : 1'b0;
    assign uart_rx_rdy   = rdy;
    assign uart_rx_level = level;
    assign uart_rx_busy  = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_multi.sv
// Randomised self-checking bench for uart_rx_multi against a frame-level model.
module tb_uart_rx_multi;

    localparam int OS = 8;

    typedef struct packed {
        logic       ferr;
        logic       perr;
        logic [7:0] d;
    } word_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pin = 1'b1;
    logic       pin_p = 1'b1;
    logic       rd = 1'b0;
    logic       rd_p = 1'b0;
    logic       clr = 1'b0;

    logic [7:0] data, data_e, data_o;
    logic       perr, perr_e, perr_o;
    logic       ferr, ferr_e, ferr_o;
    logic       rdy, rdy_e, rdy_o;
    logic       ovr, ovr_e, ovr_o;
    logic [2:0] level, level_e, level_o;
    logic       busy, busy_e, busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_multi dut (
        .uart_rx_bclk(clk), .uart_rx_rst_n(rst_n), .uart_rx_pin_raw(pin),
        .uart_rx_data(data), .uart_rx_perr(perr), .uart_rx_ferr(ferr),
        .uart_rx_rdy(rdy), .uart_rx_rd(rd), .uart_rx_ovr(ovr),
        .uart_rx_ovr_clr(clr), .uart_rx_level(level), .uart_rx_busy(busy)
    );

    uart_rx_multi #(.PARITY(1)) dut_e (
        .uart_rx_bclk(clk), .uart_rx_rst_n(rst_n), .uart_rx_pin_raw(pin_p),
        .uart_rx_data(data_e), .uart_rx_perr(perr_e), .uart_rx_ferr(ferr_e),
        .uart_rx_rdy(rdy_e), .uart_rx_rd(rd_p), .uart_rx_ovr(ovr_e),
        .uart_rx_ovr_clr(clr), .uart_rx_level(level_e), .uart_rx_busy(busy_e)
    );

    uart_rx_multi #(.PARITY(2)) dut_o (
        .uart_rx_bclk(clk), .uart_rx_rst_n(rst_n), .uart_rx_pin_raw(pin_p),
        .uart_rx_data(data_o), .uart_rx_perr(perr_o), .uart_rx_ferr(ferr_o),
        .uart_rx_rdy(rdy_o), .uart_rx_rd(rd_p), .uart_rx_ovr(ovr_o),
        .uart_rx_ovr_clr(clr), .uart_rx_level(level_o), .uart_rx_busy(busy_o)
    );

    // Expected word from the frame contents: par 0 none, 1 even, 2 odd
    function automatic word_t model(input logic [7:0] d, input int par,
                                    input logic pb, input logic stopv);
        word_t w;
        int ones;
        ones = $countones(d) + int'(pb);
        w.d = d;
        w.ferr = (stopv == 1'b0);
        if (par == 1)      w.perr = (ones % 2) == 1;
        else if (par == 2) w.perr = (ones % 2) == 0;
        else               w.perr = 1'b0;
        return w;
    endfunction

    task automatic drive(input int ch, input logic v, input int n);
        if (ch == 0) pin = v;
        else         pin_p = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int ch, input logic [7:0] d, input bit has_p,
                        input logic pb, input logic stopv);
        drive(ch, 1'b0, OS);
        for (int i = 0; i < 8; i++) drive(ch, d[i], OS);
        if (has_p) drive(ch, pb, OS);
        drive(ch, stopv, OS);
    endtask

    task automatic pop_main();
        rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
    endtask

    task automatic pop_par();
        rd_p = 1'b1;
        @(posedge clk);
        #1;
        rd_p = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pin = 1'b0;
        pin_p = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rdy, level, data, perr, ferr, ovr, busy} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b lvl=%0d data=%h p=%b f=%b ovr=%b busy=%b want all 0",
                     rdy, level, data, perr, ferr, ovr, busy);
        end
        rst_n = 1'b1;
        drive(0, 1'b0, 30);
        checks++;
        if (busy !== 1'b0 || level !== 3'd0) begin
            errors++;
            $display("FAIL reset_low_line got busy=%b lvl=%0d want 0 0", busy, level);
        end
        drive(0, 1'b1, 10);
        checks++;
        if (level !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got lvl=%0d busy=%b want 0 0", level, busy);
        end
    endtask

    task automatic test_timing();
        int n;
        n = 0;
        fork
            send(0, 8'hA5, 1'b0, 1'b0, 1'b1);
            begin
                while (n < 200) begin
                    @(negedge clk);
                    n++;
                    if (rdy) break;
                end
            end
        join
        checks++;
        if (n < 78 || n > 82) begin
            errors++;
            $display("FAIL latency got %0d want 78..82", n);
        end
        drive(0, 1'b1, 4);
        checks++;
        if ({ferr, perr, data} !== model(8'hA5, 0, 1'b0, 1'b1) || level !== 3'd1) begin
            errors++;
            $display("FAIL a5_word got f=%b p=%b d=%h lvl=%0d want 0 0 a5 1",
                     ferr, perr, data, level);
        end
        pop_main();
        checks++;
        if (rdy !== 1'b0 || level !== 3'd0) begin
            errors++;
            $display("FAIL a5_pop got rdy=%b lvl=%0d want 0 0", rdy, level);
        end
    endtask

    task automatic test_glitch();
        int nb;
        nb = 0;
        pin = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) pin = 1'b1;
            @(posedge clk);
            #1;
            if (busy) nb++;
        end
        checks++;
        if (nb > 3 || level !== 3'd0) begin
            errors++;
            $display("FAIL glitch got busy_cycles=%0d lvl=%0d want <=3 0", nb, level);
        end
    endtask

    task automatic test_parity();
        logic [7:0] d;
        logic       pb;
        word_t      we, wo;
        for (int k = 0; k < 6; k++) begin
            if (k < 2) begin
                d = 8'h03;
                pb = (k == 0);
            end else begin
                d = 8'($urandom);
                pb = 1'($urandom);
            end
            we = model(d, 1, pb, 1'b1);
            wo = model(d, 2, pb, 1'b1);
            send(1, d, 1'b1, pb, 1'b1);
            drive(1, 1'b1, 6);
            checks++;
            if ({ferr_e, perr_e, data_e} !== we || level_e !== 3'd1) begin
                errors++;
                $display("FAIL parity_even got f=%b p=%b d=%h lvl=%0d want f=%b p=%b d=%h 1",
                         ferr_e, perr_e, data_e, level_e, we.ferr, we.perr, we.d);
            end
            checks++;
            if ({ferr_o, perr_o, data_o} !== wo || level_o !== 3'd1) begin
                errors++;
                $display("FAIL parity_odd got f=%b p=%b d=%h lvl=%0d want f=%b p=%b d=%h 1",
                         ferr_o, perr_o, data_o, level_o, wo.ferr, wo.perr, wo.d);
            end
            pop_par();
        end
    endtask

    task automatic test_ferr_break();
        word_t w;
        w = model(8'h5A, 0, 1'b0, 1'b0);
        send(0, 8'h5A, 1'b0, 1'b0, 1'b0);
        drive(0, 1'b1, 8);
        checks++;
        if ({ferr, perr, data} !== w || level !== 3'd1) begin
            errors++;
            $display("FAIL ferr_5a got f=%b p=%b d=%h lvl=%0d want 1 0 5a 1",
                     ferr, perr, data, level);
        end
        pop_main();
        drive(0, 1'b0, 40 * OS);
        checks++;
        if (level !== 3'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL break_once got lvl=%0d busy=%b want 1 0", level, busy);
        end
        drive(0, 1'b1, 20);
        w = model(8'h00, 0, 1'b0, 1'b0);
        checks++;
        if ({ferr, perr, data} !== w || level !== 3'd1) begin
            errors++;
            $display("FAIL break_word got f=%b p=%b d=%h lvl=%0d want 1 0 00 1",
                     ferr, perr, data, level);
        end
        pop_main();
        w = model(8'hC3, 0, 1'b0, 1'b1);
        send(0, 8'hC3, 1'b0, 1'b0, 1'b1);
        drive(0, 1'b1, 4);
        checks++;
        if ({ferr, perr, data} !== w || level !== 3'd1) begin
            errors++;
            $display("FAIL after_break got f=%b p=%b d=%h lvl=%0d want 0 0 c3 1",
                     ferr, perr, data, level);
        end
        pop_main();
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 5; i++) send(0, 8'(i), 1'b0, 1'b0, 1'b1);
        drive(0, 1'b1, 8);
        checks++;
        if (level !== 3'd4 || ovr !== 1'b1) begin
            errors++;
            $display("FAIL overrun got lvl=%0d ovr=%b want 4 1", level, ovr);
        end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (data !== 8'(i) || rdy !== 1'b1) begin
                errors++;
                $display("FAIL ovr_read%0d got d=%h rdy=%b want %h 1", i, data, rdy, 8'(i));
            end
            pop_main();
        end
        checks++;
        if (level !== 3'd0 || ovr !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky got lvl=%0d ovr=%b want 0 1", level, ovr);
        end
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        checks++;
        if (ovr !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clr got %b want 0", ovr);
        end
    endtask

    task automatic test_spike();
        logic [7:0] d;
        int         off;
        word_t      w;
        for (int k = 0; k < 4; k++) begin
            d = (k == 0) ? 8'h3C : 8'($urandom);
            w = model(d, 0, 1'b0, 1'b1);
            drive(0, 1'b0, OS);
            for (int i = 0; i < 8; i++) begin
                off = $urandom_range(0, OS - 2);
                for (int s = 0; s < OS; s++)
                    drive(0, d[i] ^ (s == off || s == off + 1), 1);
            end
            drive(0, 1'b1, OS + 4);
            checks++;
            if ({ferr, perr, data} !== w || level !== 3'd1) begin
                errors++;
                $display("FAIL spike got f=%b p=%b d=%h lvl=%0d want 0 0 %h 1",
                         ferr, perr, data, level, d);
            end
            pop_main();
        end
    endtask

    task automatic test_random();
        word_t q[$];
        word_t w;
        int    n;
        logic [7:0] d;
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                d = 8'($urandom);
                q.push_back(model(d, 0, 1'b0, 1'b1));
                send(0, d, 1'b0, 1'b0, 1'b1);
            end
            drive(0, 1'b1, 8);
            checks++;
            if (level !== 3'(n)) begin
                errors++;
                $display("FAIL rand_level got %0d want %0d", level, n);
            end
            while (q.size() > 0) begin
                w = q.pop_front();
                checks++;
                if ({ferr, perr, data} !== w) begin
                    errors++;
                    $display("FAIL rand_word got f=%b p=%b d=%h want f=%b p=%b d=%h",
                             ferr, perr, data, w.ferr, w.perr, w.d);
                end
                pop_main();
            end
        end
    endtask

    task automatic test_reset_mid();
        word_t w;
        send(0, 8'($urandom), 1'b0, 1'b0, 1'b1);
        drive(0, 1'b1, 4);
        drive(0, 1'b0, OS);
        drive(0, 1'b1, OS);
        drive(0, 1'b0, OS);
        checks++;
        if (busy !== 1'b1 || level !== 3'd1) begin
            errors++;
            $display("FAIL mid_setup got busy=%b lvl=%0d want 1 1", busy, level);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rdy, level, data, perr, ferr, ovr, busy} !== 15'd0) begin
            errors++;
            $display("FAIL mid_reset got rdy=%b lvl=%0d d=%h busy=%b want all 0",
                     rdy, level, data, busy);
        end
        pin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 1'b1, 10);
        w = model(8'h7E, 0, 1'b0, 1'b1);
        send(0, 8'h7E, 1'b0, 1'b0, 1'b1);
        drive(0, 1'b1, 4);
        checks++;
        if ({ferr, perr, data} !== w || level !== 3'd1) begin
            errors++;
            $display("FAIL post_reset got f=%b p=%b d=%h lvl=%0d want 0 0 7e 1",
                     ferr, perr, data, level);
        end
        pop_main();
    endtask

    initial begin
        test_reset();
        test_timing();
        test_glitch();
        test_parity();
        test_ferr_break();
        test_back_to_back();
        test_spike();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_multi.md
Name: uart_rx_multi

Overview:
Parametrised oversampling UART receiver; next generation of the single-byte NVM FPGA receiver. Adds configurable data width, parity, stop bits and oversample ratio, plus majority-vote bit decisions. Received words go into a first-word-fall-through FIFO with per-word error flags, replacing the old single-byte rdy/clr handshake. Sits between the external RX pin and the command parser, clocked by the oversampled baud clock.

Parameters:
OVERSAMPLE, 8, bclk cycles per bit; even, 4..16.
DATA_BITS, 8, data bits per frame, 5..9, LSB first.
PARITY, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, 1 or 2.
FIFO_DEPTH, 4, words; power of 2, 2..16.

Ports:
uart_rx_bclk  in  1  oversampled baud clock (OVERSAMPLE x baud)
uart_rx_rst_n  in  1  asynchronous active-low reset
uart_rx_pin_raw  in  1  asynchronous serial input, idle high
uart_rx_data  out  DATA_BITS  FIFO head word
uart_rx_perr  out  1  parity error flag of head word (0 when PARITY=0)
uart_rx_ferr  out  1  framing error flag of head word
uart_rx_rdy  out  1  FIFO not empty; head outputs valid
uart_rx_rd  in  1  pop head when uart_rx_rdy=1; ignored otherwise
uart_rx_ovr  out  1  sticky overrun: a frame was dropped because the FIFO was full
uart_rx_ovr_clr  in  1  synchronous clear of uart_rx_ovr
uart_rx_level  out  clog2(FIFO_DEPTH)+1  words in FIFO
uart_rx_busy  out  1  frame in progress (state != IDLE)

Behaviour:
- Reset (async, active low): two-flop pin synchroniser = 1, state = IDLE, counters = 0, FIFO empty. All outputs 0 (uart_rx_data = 0). Releasing reset while the line is low must not start a frame until the line has been seen high once.
- Sampling: all decisions use the synchronised pin, which lags the raw pin by 2 cycles.
- IDLE: count consecutive low samples. A high sample clears the count (false start: nothing pushed). At OVERSAMPLE/2 consecutive lows go to START_REST.
- START_REST: wait OVERSAMPLE/2 cycles, then go to DATA. Bit windows are now aligned to bit boundaries.
- Bit decision (DATA, PARITY, STOP): each window is OVERSAMPLE samples, indexed 0..OVERSAMPLE-1. Count zeros over samples 1..OVERSAMPLE-2. The bit is 0 iff 2*zeros > OVERSAMPLE-2; a tie decodes as 1.
- DATA: DATA_BITS windows, shifted in LSB first. Then go to PARITY if PARITY != 0, else to STOP.
- PARITY: one window. perr = XOR(data bits, parity bit) XOR (PARITY==2); the result is 0 when correct.
- STOP: for each non-final stop bit, use a full window. For the final stop bit, vote on samples 1..OVERSAMPLE/2 only, then push and return to IDLE at sample OVERSAMPLE/2. This tolerates back-to-back frames and clock skew. ferr = 1 if any stop bit decodes 0. A frame with ferr is still pushed.
- Push: a single-cycle push of {ferr, perr, data} on the cycle the final stop decision is made. The word is visible on the outputs the next cycle.
- FIFO is first-word-fall-through. A pop with rdy=1 advances the head the next cycle. Level updates on the same edge as push/pop.
- Push while full without a simultaneous pop: word dropped, uart_rx_ovr set, FIFO unchanged. Push and pop in the same cycle while full: both happen, no overrun. Push and pop in the same cycle while empty: the pop is ignored and the push is stored.
- ovr_clr and an overrun event in the same cycle: set wins. Pointers wrap modulo FIFO_DEPTH.
- Line held low continuously (break): decodes as data 0 with ferr=1, pushed once. The receiver then stays in IDLE with the count saturated at OVERSAMPLE/2 and does not restart until the line has been high for at least one sample.

Test Plan:
- Defaults, send 8N1 0xA5 at 8 bclk/bit -> rdy rises 80±2 cycles after the falling start edge; data=0xA5, perr=0, ferr=0, level=1; pulse rd -> rdy=0, level=0.
- Low glitch of 3 samples on an idle line -> busy pulses at most 3 cycles, nothing pushed, level stays 0.
- PARITY=1, send 0x03 with parity bit 1 -> perr=1; with parity bit 0 -> perr=0. PARITY=2, 0x03 with parity bit 1 -> perr=0.
- Stop bit forced low on 0x5A -> word 0x5A pushed with ferr=1. Then hold the line low for 40 bit times -> exactly one 0x00 with ferr=1, and no further pushes until the line returns high.
- FIFO_DEPTH=4, send 5 back-to-back frames 0x01..0x05 without reading -> level=4, ovr=1, reads return 0x01..0x04. ovr_clr -> ovr=0.
- Single 2-sample inverted spike inside each data window of 0x3C (OVERSAMPLE=8) -> decoded 0x3C. Assert reset mid-frame -> all outputs 0 immediately; next clean frame 0x7E is received correctly.
